codificacao: RTL
================

Name: codificacao

Overview:
- Instruction encoder, the inverse of the datapath decode stage.
- Accepts decoded fields (opcode, registers, funct, immediate, format code) over a valid/ready handshake and packs them into a 32-bit RV32 word.
- Writes the word into instruction memory at an auto-incrementing word address.
- Used by the bench/loader path to build programs for the datapath.

Parameters:
ADDR_W, 8, width of instruction-memory word address; address wraps modulo 2^ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
tipo  input  3  format code: 000 I, 010 S, 011 R, 110 SB
opcode  input  7  opcode field
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R only)
immediate  input  12  12-bit immediate (I, S, SB)
limpar  input  1  synchronous clear of write address
instrucao  output  32  packed instruction word
endereco  output  ADDR_W  word address for the current/next write
we  output  1  memory write strobe, one cycle
erro  output  1  one-cycle pulse on rejected bundle

Behaviour:
- Reset is asynchronous, active-low. While rst_n is low:
  - State is OCIOSO.
  - in_ready=0, instrucao=0, endereco=0, we=0, erro=0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States and transitions:
  - OCIOSO: in_ready=1 unless limpar=1. On in_valid & in_ready, latch all fields and go to MONTA.
  - MONTA (1 cycle): validate the bundle and pack it into instrucao.
    - Valid bundle: go to ESCREVE.
    - Invalid bundle: erro=1 for one cycle, instrucao unchanged, go to OCIOSO.
  - ESCREVE (1 cycle): we=1 with the current instrucao and endereco. On exit, endereco increments by 1 and state returns to OCIOSO.
- in_ready is 0 in MONTA and ESCREVE. Throughput is one bundle per 3 cycles. Handshake-to-we latency is 2 cycles.
- Validation: the bundle is invalid if tipo is not in {000, 010, 011, 110}, or if opcode[6:4] != tipo.
- Packing, bit 31 down to 0:
  - I: immediate[11:0], rs1, funct3, rd, opcode
  - S: immediate[11:5], rs2, rs1, funct3, immediate[4:0], opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - SB: identical placement to S. This is the datapath's SB convention, not the ratified B-type bit scramble.
- Fields unused by a format are ignored (for example rs2 for I, rd for S/SB).
- instrucao holds its last packed value until the next valid MONTA.
- Address:
  - Increments only on ESCREVE exit.
  - Wraps from 2^ADDR_W-1 to 0 silently.
  - No increment on a rejected bundle.
- limpar:
  - Sampled only in OCIOSO. Sets endereco=0 at the next edge.
  - Has priority over acceptance: in_ready=0 while limpar=1.
  - Ignored in MONTA and ESCREVE. The in-flight write completes and increments.
- Handshake: in_valid may be held across the busy cycles. The bundle is accepted only in OCIOSO, and fields must be stable until accepted.
- Reset mid-operation: an asynchronous rst_n low in MONTA or ESCREVE drops we immediately. No write completes and endereco returns to 0.

Test Plan:
- Reset, then I bundle (tipo=000, opcode=0000011, rd=5, rs1=2, funct3=010, immediate=0x004) -> two edges after handshake: we=1, instrucao=0x00412283, endereco=0; endereco=1 next cycle.
- R bundle (tipo=011, opcode=0110011, rd=3, rs1=1, rs2=2, funct3=000, funct7=0) then S bundle (tipo=010, opcode=0100011, rs1=2, rs2=6, funct3=010, immediate=0x008) -> writes 0x002081B3 at addr 0 and 0x00612423 at addr 1. in_ready=0 for exactly 2 cycles after each handshake.
- SB bundle (tipo=110, opcode=1100011, rs1=1, rs2=2, funct3=000, immediate=0x010) -> instrucao=0x00208863, we pulse.
- Mismatch (tipo=011, opcode=0000011) and illegal tipo=101 -> erro pulses for 1 cycle each, we stays 0, endereco unchanged, instrucao unchanged.
- ADDR_W=2, five valid writes -> addresses 0,1,2,3,0. limpar in OCIOSO afterwards -> endereco=0 and in_ready=0 during that cycle.
- rst_n pulsed low during ESCREVE -> we falls without waiting for clk, all outputs return to reset values, next accepted bundle writes to address 0.

Source files
------------

// File: rtl/codificacao.sv
// codificacao: packs decoded RV32 fields into an instruction word and writes it to auto-incrementing memory addresses
module codificacao #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        tipo,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       immediate,
  input  logic              limpar,
  output logic [31:0]       instrucao,
  output logic [ADDR_W-1:0] endereco,
  output logic              we,
  output logic              erro
);
  typedef enum logic [1:0] {OCIOSO, MONTA, ESCREVE} estado_t;
  estado_t estado_q, estado_d;
  logic rdy_q;
  logic [2:0] tipo_q, f3_q;
  logic [6:0] op_q, f7_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [11:0] imm_q;
  logic [31:0] instr_q, instr_d, pacote;
  logic [ADDR_W-1:0] end_q, end_d;
  logic aceita, valido;
  // rdy_q keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy_q && estado_q == OCIOSO && !limpar;
  assign aceita    = in_valid && in_ready;
  assign valido    = (tipo_q inside {3'b000, 3'b010, 3'b011, 3'b110}) && op_q[6:4] == tipo_q;
  assign we        = estado_q == ESCREVE;
  assign erro      = estado_q == MONTA && !valido;
  assign instrucao = instr_q;
  assign endereco  = end_q;
  // SB shares the S placement: this datapath does not use the B-type bit scramble
  always_comb begin
    pacote   = tipo_q == 3'b011 ? {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q}
             : tipo_q == 3'b000 ? {imm_q, rs1_q, f3_q, rd_q, op_q}
             : {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
    estado_d = estado_q == OCIOSO ? (aceita ? MONTA : OCIOSO)
             : estado_q == MONTA ? (valido ? ESCREVE : OCIOSO)
             : OCIOSO;
    instr_d  = (estado_q == MONTA && valido) ? pacote : instr_q;
    end_d    = we ? end_q + 1'b1 : (estado_q == OCIOSO && limpar) ? '0 : end_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      rdy_q    <= 1'b0;
      instr_q  <= '0;
      end_q    <= '0;
      tipo_q   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      f3_q     <= '0;
      f7_q     <= '0;
      imm_q    <= '0;
    end else begin
      estado_q <= estado_d;
      rdy_q    <= 1'b1;
      instr_q  <= instr_d;
      end_q    <= end_d;
      if (aceita) begin
        tipo_q <= tipo;
        op_q   <= opcode;
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        f3_q   <= funct3;
        f7_q   <= funct7;
        imm_q  <= immediate;
      end
    end
  end
endmodule
